// File: rtl/bp_pkg.sv
// Shared types and sizing for the branch-predictor update arbiter.
// Holds the table geometry, the write-kind encoding for the table write
// port, the arbiter FSM state encoding and the queued update record.
package bp_pkg;

    localparam int BP_ENTRIES   = 4;
    localparam int BP_IDX_W     = $clog2(BP_ENTRIES);
    localparam int BP_UPD_DEPTH = 4;
    localparam int BP_UPD_AW    = $clog2(BP_UPD_DEPTH);
    localparam int BP_XLEN      = 32;

    // Kind of write presented on the table write port.
    typedef enum logic [1:0] {
        WR_ALLOC  = 2'd0,
        WR_UPDATE = 2'd1,
        WR_INVAL  = 2'd2
    } bp_wr_kind_e;

    // Arbiter state: records what the write port was granted last cycle.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_GRANT_ALLOC = 2'd1,
        ST_GRANT_UPD   = 2'd2,
        ST_FLUSH       = 2'd3
    } bp_state_e;

    // One queued EXEC outcome update.
    typedef struct packed {
        logic [BP_IDX_W-1:0] index;
        logic                taken;
        logic                valid;
    } bp_upd_t;

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Bundle of the DECODE allocation channel, the EXEC update channel and the
// predictor-table write port.
//   master : pipeline side (drives alloc_* / upd_* requests, observes wr_*)
//   slave  : arbiter side (returns ready/index, drives wr_* and state_dbg)
//
// Handshake: a transfer on a channel happens in exactly the cycle where
// *_req and *_ready are both high at the rising clock edge. The requester
// keeps its payload stable while *_req is high and not yet accepted; ready
// may depend combinationally on req, req never depends on ready.
interface bp_update_arbiter_if;
    import bp_pkg::*;

    logic                alloc_req;
    logic [BP_XLEN-1:0]  alloc_pc;
    logic [BP_XLEN-1:0]  alloc_target;
    logic                alloc_ready;
    logic [BP_IDX_W-1:0] alloc_index;

    logic                upd_req;
    logic [BP_IDX_W-1:0] upd_index;
    logic                upd_taken;
    logic                upd_ready;

    logic                wr_en;
    bp_wr_kind_e         wr_kind;
    logic [BP_IDX_W-1:0] wr_index;
    logic [BP_XLEN-1:0]  wr_pc;
    logic [BP_XLEN-1:0]  wr_target;
    logic                wr_taken;

    bp_state_e           state_dbg;

    modport master (
        output alloc_req, alloc_pc, alloc_target, upd_req, upd_index, upd_taken,
        input  alloc_ready, alloc_index, upd_ready,
        input  wr_en, wr_kind, wr_index, wr_pc, wr_target, wr_taken, state_dbg
    );

    modport slave (
        input  alloc_req, alloc_pc, alloc_target, upd_req, upd_index, upd_taken,
        output alloc_ready, alloc_index, upd_ready,
        output wr_en, wr_kind, wr_index, wr_pc, wr_target, wr_taken, state_dbg
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// Update queue with per-entry invalidate-by-index.
// The storage is kept compacted: slot 0 is always the oldest live entry, so
// entries removed by invalidation vanish on the same edge and never cost a
// pop cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 drop every entry
//   push, push_index,
//   push_taken            append one update (ignored when no slot is free)
//   pop                   remove the head entry
//   inv_en, inv_index     remove every entry whose index matches
//   head                  oldest entry; head.valid = queue non-empty
//   full                  every slot occupied
module bp_upd_fifo
    import bp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                push,
    input  logic [BP_IDX_W-1:0] push_index,
    input  logic                push_taken,
    input  logic                pop,
    input  logic                inv_en,
    input  logic [BP_IDX_W-1:0] inv_index,
    output bp_upd_t             head,
    output logic                full
);

    bp_upd_t              q     [BP_UPD_DEPTH];
    bp_upd_t              q_nxt [BP_UPD_DEPTH];
    logic [BP_UPD_AW:0]   fill;

    // Keep the survivors in order, then append the pushed entry behind them.
    always_comb begin
        for (int i = 0; i < BP_UPD_DEPTH; i++) begin
            q_nxt[i] = '0;
        end
        fill = '0;
        if (!clear) begin
            for (int i = 0; i < BP_UPD_DEPTH; i++) begin
                if (q[i].valid && !(pop && i == 0) &&
                    !(inv_en && q[i].index == inv_index)) begin
                    q_nxt[fill[BP_UPD_AW-1:0]] = q[i];
                    fill = fill + 1'b1;
                end
            end
            if (push && int'(fill) < BP_UPD_DEPTH) begin
                q_nxt[fill[BP_UPD_AW-1:0]].valid = 1'b1;
                q_nxt[fill[BP_UPD_AW-1:0]].index = push_index;
                q_nxt[fill[BP_UPD_AW-1:0]].taken = push_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BP_UPD_DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BP_UPD_DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
        end
    end

    assign head = q[0];
    assign full = q[BP_UPD_DEPTH-1].valid;

endmodule

// File: rtl/bp_update_arbiter.sv
// Branch-predictor table write arbiter.
// Serialises DECODE allocations, queued EXEC updates and flush
// invalidations onto one registered table write port (one write per cycle,
// presented the cycle after the request is granted).
// Optional feature macro: BP_UPD_BYPASS_EN -- when defined, an update that
// arrives with the queue empty and no allocation requested is written
// directly, skipping the queue cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  invalidate every entry (INVAL sweep 0..3)
//   busy   high while the INVAL sweep is on the write port
//   bus    allocation / update channels and table write port (slave side)
module bp_update_arbiter
    import bp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    output logic                  busy,
    bp_update_arbiter_if.slave    bus
);

    localparam logic [BP_IDX_W-1:0] LAST_IDX = BP_IDX_W'(BP_ENTRIES - 1);

    bp_state_e           state_q, state_d;
    logic                ready_q;
    logic [BP_IDX_W-1:0] ptr_q, ptr_d;
    logic [1:0]          starve_q, starve_d;

    logic                wr_en_q, wr_en_d;
    bp_wr_kind_e         wr_kind_q, wr_kind_d;
    logic [BP_IDX_W-1:0] wr_index_q, wr_index_d;
    logic [BP_XLEN-1:0]  wr_pc_q, wr_pc_d;
    logic [BP_XLEN-1:0]  wr_target_q, wr_target_d;
    logic                wr_taken_q, wr_taken_d;

    bp_upd_t             fifo_head;
    logic                fifo_full;
    logic                fifo_has;
    logic                active;
    logic                starve;
    logic                alloc_fire;
    logic                pop;
    logic                upd_fire;
    logic                bypass;
    logic                drop;
    logic                push;

    // Requests are only taken once out of reset, outside the sweep, and not
    // in a cycle whose work a flush is about to discard.
    assign active     = ready_q && (state_q != ST_FLUSH) && !flush;
    assign fifo_has   = fifo_head.valid;
    // Two back-to-back allocations with updates waiting: yield one cycle.
    assign starve     = (starve_q == 2'd2) && fifo_has;
    assign alloc_fire = bus.alloc_req && bus.alloc_ready;
    assign pop        = active && !alloc_fire && fifo_has;
    assign upd_fire   = bus.upd_req && bus.upd_ready;
`ifdef BP_UPD_BYPASS_EN
    assign bypass     = upd_fire && !fifo_has && !bus.alloc_req;
`else
    assign bypass     = 1'b0;
`endif
    // An update racing an allocation of the same entry is stale: drop it.
    assign drop       = alloc_fire && (bus.upd_index == ptr_q);
    assign push       = upd_fire && !drop && !bypass;

    assign bus.alloc_ready = active && !starve;
    assign bus.alloc_index = ptr_q;
    // A full queue still accepts when its head leaves in the same cycle.
    assign bus.upd_ready   = active && (!fifo_full || pop);

    bp_upd_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .push       (push),
        .push_index (bus.upd_index),
        .push_taken (bus.upd_taken),
        .pop        (pop),
        .inv_en     (alloc_fire),
        .inv_index  (ptr_q),
        .head       (fifo_head),
        .full       (fifo_full)
    );

    // Grant decision. In FLUSH the registered wr_index is the sweep
    // position currently shown on the write port.
    always_comb begin
        state_d     = ST_IDLE;
        ptr_d       = ptr_q;
        starve_d    = 2'd0;
        wr_en_d     = 1'b0;
        wr_kind_d   = WR_ALLOC;
        wr_index_d  = '0;
        wr_pc_d     = '0;
        wr_target_d = '0;
        wr_taken_d  = 1'b0;
        if (flush) begin
            state_d    = ST_FLUSH;
            ptr_d      = '0;
            wr_en_d    = 1'b1;
            wr_kind_d  = WR_INVAL;
        end else if (state_q == ST_FLUSH) begin
            ptr_d = '0;
            if (wr_index_q != LAST_IDX) begin
                state_d    = ST_FLUSH;
                wr_en_d    = 1'b1;
                wr_kind_d  = WR_INVAL;
                wr_index_d = wr_index_q + BP_IDX_W'(1);
            end
        end else if (alloc_fire) begin
            state_d     = ST_GRANT_ALLOC;
            ptr_d       = ptr_q + BP_IDX_W'(1);
            wr_en_d     = 1'b1;
            wr_kind_d   = WR_ALLOC;
            wr_index_d  = ptr_q;
            wr_pc_d     = bus.alloc_pc;
            wr_target_d = bus.alloc_target;
            if (fifo_has || push) begin
                starve_d = (starve_q == 2'd2) ? 2'd2 : starve_q + 2'd1;
            end
        end else if (pop) begin
            state_d    = ST_GRANT_UPD;
            wr_en_d    = 1'b1;
            wr_kind_d  = WR_UPDATE;
            wr_index_d = fifo_head.index;
            wr_taken_d = fifo_head.taken;
        end else if (bypass) begin
            state_d    = ST_GRANT_UPD;
            wr_en_d    = 1'b1;
            wr_kind_d  = WR_UPDATE;
            wr_index_d = bus.upd_index;
            wr_taken_d = bus.upd_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            starve_q    <= 2'd0;
            wr_en_q     <= 1'b0;
            wr_kind_q   <= WR_ALLOC;
            wr_index_q  <= '0;
            wr_pc_q     <= '0;
            wr_target_q <= '0;
            wr_taken_q  <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            starve_q    <= starve_d;
            wr_en_q     <= wr_en_d;
            wr_kind_q   <= wr_kind_d;
            wr_index_q  <= wr_index_d;
            wr_pc_q     <= wr_pc_d;
            wr_target_q <= wr_target_d;
            wr_taken_q  <= wr_taken_d;
        end
    end

    assign busy          = (state_q == ST_FLUSH);
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_kind   = wr_kind_q;
    assign bus.wr_index  = wr_index_q;
    assign bus.wr_pc     = wr_pc_q;
    assign bus.wr_target = wr_target_q;
    assign bus.wr_taken  = wr_taken_q;
    assign bus.state_dbg = state_q;

endmodule
